// File: rtl/cluster_ctrl_pkg.sv
// Shared types and constants for the cluster load controller: slot tokens,
// sequencer states, multicast register count and the idle tag value.
package cluster_ctrl_pkg;

   typedef enum logic [3:0] {
      TOK_NONE,
      TOK_AID,
      TOK_WID,
      TOK_AWREN,
      TOK_WWREN,
      TOK_WTAGY,
      TOK_WTAGX,
      TOK_WDATA,
      TOK_ATAGY,
      TOK_ATAGX,
      TOK_ADATA,
      TOK_START
   } tok_e;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SCAN_A,
      ST_WREN_A,
      ST_SCAN_W,
      ST_WREN_W,
      ST_LOAD_W,
      ST_LOAD_A,
      ST_GAP,
      ST_START,
      ST_WAIT_DONE,
      ST_DONE
   } state_e;

   localparam int unsigned TAG_MAX_W = 32;
   localparam logic [TAG_MAX_W-1:0] IDLE_TAG = '1;

   // One register per PE plus one per row head in each multicast network.
   function automatic int calc_p(input int pe_x, input int pe_y);
      return pe_y * pe_x + pe_y;
   endfunction

endpackage

// File: rtl/cluster_load_ctrl_if.sv
// Host config, descriptor memory and PE cluster signals of the load controller;
// master is the controller side, slave the surrounding system.
interface cluster_load_ctrl_if #(
   parameter int dataSize    = 8,
   parameter int idSize      = 8,
   parameter int memAddrSize = 16
);
   logic                   cfg_start_i;
   logic [memAddrSize-1:0] cfg_base_addr_i;
   logic [7:0]             cfg_acount_i;
   logic [7:0]             cfg_wcount_i;
   logic                   busy_o;
   logic                   done_o;
   logic                   cfg_err_o;
   logic                   mem_rd_en_o;
   logic [memAddrSize-1:0] mem_rd_addr_o;
   logic [dataSize-1:0]    mem_rd_data_i;
   logic                   cluster_enable_o;
   logic [7:0]             ctrl_acount_o;
   logic [7:0]             ctrl_wcount_o;
   logic [idSize-1:0]      act_id_scan_o;
   logic [idSize-1:0]      weight_id_scan_o;
   logic                   act_id_wren_o;
   logic                   weight_id_wren_o;
   logic [dataSize-1:0]    w_data_o;
   logic [dataSize-1:0]    a_data_o;
   logic [idSize-1:0]      weight_mcn_tag_target_x_o;
   logic [idSize-1:0]      weight_mcn_tag_target_y_o;
   logic [idSize-1:0]      act_mcn_tag_target_x_o;
   logic [idSize-1:0]      act_mcn_tag_target_y_o;
   logic                   start_compute_o;
   logic                   flag_done_i;

   modport master (
      input  cfg_start_i, cfg_base_addr_i, cfg_acount_i, cfg_wcount_i,
      input  mem_rd_data_i, flag_done_i,
      output busy_o, done_o, cfg_err_o, mem_rd_en_o, mem_rd_addr_o,
      output cluster_enable_o, ctrl_acount_o, ctrl_wcount_o,
      output act_id_scan_o, weight_id_scan_o, act_id_wren_o, weight_id_wren_o,
      output w_data_o, a_data_o,
      output weight_mcn_tag_target_x_o, weight_mcn_tag_target_y_o,
      output act_mcn_tag_target_x_o, act_mcn_tag_target_y_o,
      output start_compute_o
   );

   modport slave (
      output cfg_start_i, cfg_base_addr_i, cfg_acount_i, cfg_wcount_i,
      output mem_rd_data_i, flag_done_i,
      input  busy_o, done_o, cfg_err_o, mem_rd_en_o, mem_rd_addr_o,
      input  cluster_enable_o, ctrl_acount_o, ctrl_wcount_o,
      input  act_id_scan_o, weight_id_scan_o, act_id_wren_o, weight_id_wren_o,
      input  w_data_o, a_data_o,
      input  weight_mcn_tag_target_x_o, weight_mcn_tag_target_y_o,
      input  act_mcn_tag_target_x_o, act_mcn_tag_target_y_o,
      input  start_compute_o
   );

endinterface

// File: rtl/cluster_ctrl_tok_pipe.sv
// Token pipeline: holds each slot token until its memory word arrives, then
// decodes token plus word into the registered cluster-facing outputs.
module cluster_ctrl_tok_pipe
   import cluster_ctrl_pkg::*;
#(
   parameter int dataSize = 8,
   parameter int idSize   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  tok_e                tok_p0,
   input  logic [dataSize-1:0] rd_data,
   output logic [idSize-1:0]   act_id_scan,
   output logic [idSize-1:0]   weight_id_scan,
   output logic                act_id_wren,
   output logic                weight_id_wren,
   output logic [dataSize-1:0] w_data,
   output logic [dataSize-1:0] a_data,
   output logic [idSize-1:0]   w_tag_x,
   output logic [idSize-1:0]   w_tag_y,
   output logic [idSize-1:0]   a_tag_x,
   output logic [idSize-1:0]   a_tag_y,
   output logic                start_compute
);

   localparam logic [idSize-1:0] TAG_IDLE = IDLE_TAG[idSize-1:0];

   tok_e              tok_p1;
   logic [idSize-1:0] rd_id;
   logic [idSize-1:0] w_shadow_x;
   logic [idSize-1:0] w_shadow_y;
   logic [idSize-1:0] a_shadow_x;
   logic [idSize-1:0] a_shadow_y;

   assign rd_id = rd_data[idSize-1:0];

   // p1: token aligned with the returning memory word; decode lands one edge later
   always_ff @(posedge clk) begin
      if (rst) begin
         tok_p1         <= TOK_NONE;
         act_id_scan    <= TAG_IDLE;
         weight_id_scan <= TAG_IDLE;
         act_id_wren    <= 1'b0;
         weight_id_wren <= 1'b0;
         w_data         <= '0;
         a_data         <= '0;
         w_tag_x        <= TAG_IDLE;
         w_tag_y        <= TAG_IDLE;
         a_tag_x        <= TAG_IDLE;
         a_tag_y        <= TAG_IDLE;
         w_shadow_x     <= TAG_IDLE;
         w_shadow_y     <= TAG_IDLE;
         a_shadow_x     <= TAG_IDLE;
         a_shadow_y     <= TAG_IDLE;
         start_compute  <= 1'b0;
      end else begin
         tok_p1         <= tok_p0;
         act_id_wren    <= (tok_p1 == TOK_AWREN);
         weight_id_wren <= (tok_p1 == TOK_WWREN);
         start_compute  <= (tok_p1 == TOK_START);
         // Targets leave the idle value only alongside their own data word.
         w_tag_x        <= TAG_IDLE;
         w_tag_y        <= TAG_IDLE;
         a_tag_x        <= TAG_IDLE;
         a_tag_y        <= TAG_IDLE;
         case (tok_p1)
            TOK_AID:   act_id_scan    <= rd_id;
            TOK_WID:   weight_id_scan <= rd_id;
            TOK_WTAGY: w_shadow_y     <= rd_id;
            TOK_WTAGX: w_shadow_x     <= rd_id;
            TOK_ATAGY: a_shadow_y     <= rd_id;
            TOK_ATAGX: a_shadow_x     <= rd_id;
            TOK_WDATA: begin
               w_data  <= rd_data;
               w_tag_x <= w_shadow_x;
               w_tag_y <= w_shadow_y;
            end
            TOK_ADATA: begin
               a_data  <= rd_data;
               a_tag_x <= a_shadow_x;
               a_tag_y <= a_shadow_y;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cluster_load_ctrl.sv
// Sequencer that walks a contiguous descriptor (IDs, weight rows, act rows),
// issuing one slot token per cycle, then starts the cluster and waits for done.
module cluster_load_ctrl
   import cluster_ctrl_pkg::*;
#(
   parameter int numPeX      = 14,
   parameter int numPeY      = 3,
   parameter int dataSize    = 8,
   parameter int idSize      = 8,
   parameter int memAddrSize = 16
) (
   input logic                 clk,
   input logic                 rst,
   cluster_load_ctrl_if.master cif
);

   localparam int P = calc_p(numPeX, numPeY);
   localparam logic [15:0] P_LAST = 16'(P - 1);
   localparam logic [memAddrSize-1:0] ADDR_ONE = {{(memAddrSize-1){1'b0}}, 1'b1};

   state_e                 state;
   tok_e                   tok_p0;
   logic [15:0]            cnt;
   logic [7:0]             row;
   logic                   armed;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic                   enable;
   logic                   rd_en;
   logic [memAddrSize-1:0] rd_addr;
   logic [memAddrSize-1:0] addr_next;
   logic [7:0]             acnt;
   logic [7:0]             wcnt;
   logic [15:0]            w_last_col;
   logic [15:0]            a_last_col;
   logic                   start_bad;

   assign addr_next  = rd_addr + ADDR_ONE;
   // Each row is tagY, tagX, then as many words as the row count.
   assign w_last_col = {8'd0, wcnt} + 16'd1;
   assign a_last_col = {8'd0, acnt} + 16'd1;
   assign start_bad  = (cif.cfg_wcount_i == 8'd0) || (cif.cfg_acount_i < cif.cfg_wcount_i);

   // p0: state, read request and slot token are registered together
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tok_p0  <= TOK_NONE;
         cnt     <= '0;
         row     <= '0;
         armed   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         enable  <= 1'b0;
         rd_en   <= 1'b0;
         rd_addr <= '0;
         acnt    <= '0;
         wcnt    <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cif.cfg_start_i) begin
                  if (start_bad) begin
                     err <= 1'b1;
                  end else begin
                     state   <= ST_SCAN_A;
                     busy    <= 1'b1;
                     enable  <= 1'b1;
                     acnt    <= cif.cfg_acount_i;
                     wcnt    <= cif.cfg_wcount_i;
                     cnt     <= '0;
                     rd_en   <= 1'b1;
                     rd_addr <= cif.cfg_base_addr_i;
                     tok_p0  <= TOK_AID;
                  end
               end
            end
            ST_SCAN_A: begin
               if (cnt == P_LAST) begin
                  state  <= ST_WREN_A;
                  rd_en  <= 1'b0;
                  tok_p0 <= TOK_AWREN;
               end else begin
                  cnt     <= cnt + 16'd1;
                  rd_addr <= addr_next;
                  tok_p0  <= TOK_AID;
               end
            end
            ST_WREN_A: begin
               state   <= ST_SCAN_W;
               cnt     <= '0;
               rd_en   <= 1'b1;
               rd_addr <= addr_next;
               tok_p0  <= TOK_WID;
            end
            ST_SCAN_W: begin
               if (cnt == P_LAST) begin
                  state  <= ST_WREN_W;
                  rd_en  <= 1'b0;
                  tok_p0 <= TOK_WWREN;
               end else begin
                  cnt     <= cnt + 16'd1;
                  rd_addr <= addr_next;
                  tok_p0  <= TOK_WID;
               end
            end
            ST_WREN_W: begin
               state   <= ST_LOAD_W;
               cnt     <= '0;
               row     <= '0;
               rd_en   <= 1'b1;
               rd_addr <= addr_next;
               tok_p0  <= TOK_WTAGY;
            end
            ST_LOAD_W: begin
               rd_addr <= addr_next;
               if (cnt != w_last_col) begin
                  cnt    <= cnt + 16'd1;
                  tok_p0 <= (cnt == 16'd0) ? TOK_WTAGX : TOK_WDATA;
               end else if (row != wcnt - 8'd1) begin
                  cnt    <= '0;
                  row    <= row + 8'd1;
                  tok_p0 <= TOK_WTAGY;
               end else begin
                  state  <= ST_LOAD_A;
                  cnt    <= '0;
                  row    <= '0;
                  tok_p0 <= TOK_ATAGY;
               end
            end
            ST_LOAD_A: begin
               if (cnt != a_last_col) begin
                  cnt     <= cnt + 16'd1;
                  rd_addr <= addr_next;
                  tok_p0  <= (cnt == 16'd0) ? TOK_ATAGX : TOK_ADATA;
               end else if (row != acnt - 8'd1) begin
                  cnt     <= '0;
                  row     <= row + 8'd1;
                  rd_addr <= addr_next;
                  tok_p0  <= TOK_ATAGY;
               end else begin
                  state  <= ST_GAP;
                  rd_en  <= 1'b0;
                  tok_p0 <= TOK_NONE;
               end
            end
            ST_GAP: begin
               state  <= ST_START;
               tok_p0 <= TOK_START;
            end
            ST_START: begin
               state  <= ST_WAIT_DONE;
               tok_p0 <= TOK_NONE;
               armed  <= 1'b0;
            end
            ST_WAIT_DONE: begin
               // Done only counts once the start pulse has actually left the pipe.
               armed <= armed | cif.start_compute_o;
               if (armed && cif.flag_done_i) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               enable <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cif.busy_o           = busy;
   assign cif.done_o           = done;
   assign cif.cfg_err_o        = err;
   assign cif.mem_rd_en_o      = rd_en;
   assign cif.mem_rd_addr_o    = rd_addr;
   assign cif.cluster_enable_o = enable;
   assign cif.ctrl_acount_o    = acnt;
   assign cif.ctrl_wcount_o    = wcnt;

   cluster_ctrl_tok_pipe #(
      .dataSize (dataSize),
      .idSize   (idSize)
   ) u_tok_pipe (
      .clk            (clk),
      .rst            (rst),
      .tok_p0         (tok_p0),
      .rd_data        (cif.mem_rd_data_i),
      .act_id_scan    (cif.act_id_scan_o),
      .weight_id_scan (cif.weight_id_scan_o),
      .act_id_wren    (cif.act_id_wren_o),
      .weight_id_wren (cif.weight_id_wren_o),
      .w_data         (cif.w_data_o),
      .a_data         (cif.a_data_o),
      .w_tag_x        (cif.weight_mcn_tag_target_x_o),
      .w_tag_y        (cif.weight_mcn_tag_target_y_o),
      .a_tag_x        (cif.act_mcn_tag_target_x_o),
      .a_tag_y        (cif.act_mcn_tag_target_y_o),
      .start_compute  (cif.start_compute_o)
   );

endmodule

// File: tb/tb_cluster_load_ctrl.sv
// Randomized bench for cluster_load_ctrl against a slot-list reference model.
module tb_cluster_load_ctrl;

   localparam int NX = 4;
   localparam int NY = 3;
   localparam int DW = 8;
   localparam int IW = 8;
   localparam int AW = 16;
   localparam int P  = NY * NX + NY;

   localparam int K_NONE = 0, K_AID = 1, K_WID = 2, K_AWR = 3, K_WWR = 4;
   localparam int K_WTY = 5, K_WTX = 6, K_WD = 7, K_ATY = 8, K_ATX = 9, K_AD = 10, K_ST = 11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cluster_load_ctrl_if #(.dataSize(DW), .idSize(IW), .memAddrSize(AW)) cif ();

   cluster_load_ctrl #(
      .numPeX(NX), .numPeY(NY), .dataSize(DW), .idSize(IW), .memAddrSize(AW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .cif (cif)
   );

   int n_tests;
   int n_fail;
   logic [7:0] salt;
   logic [7:0] m_ascan, m_wscan, m_wdata, m_adata;
   logic [7:0] m_wty, m_wtx, m_aty, m_atx;
   logic [7:0] m_acnt, m_wcnt;

   function automatic logic [7:0] word_of(input logic [15:0] ad);
      return ad[7:0] ^ salt;
   endfunction

   function automatic bit is_read(input int k);
      return k inside {K_AID, K_WID, K_WTY, K_WTX, K_WD, K_ATY, K_ATX, K_AD};
   endfunction

   // descriptor memory: word available the cycle after the request
   always @(posedge clk)
      if (cif.mem_rd_en_o) cif.mem_rd_data_i <= word_of(cif.mem_rd_addr_o);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ascan = 8'hFF; m_wscan = 8'hFF; m_wdata = 8'h00; m_adata = 8'h00;
      m_wty = 8'hFF; m_wtx = 8'hFF; m_aty = 8'hFF; m_atx = 8'hFF;
      m_acnt = 8'h00; m_wcnt = 8'h00;
   endtask

   task automatic check_reset_state();
      check("rst_busy", cif.busy_o, 0);
      check("rst_done", cif.done_o, 0);
      check("rst_err", cif.cfg_err_o, 0);
      check("rst_rd_en", cif.mem_rd_en_o, 0);
      check("rst_rd_addr", cif.mem_rd_addr_o, 0);
      check("rst_enable", cif.cluster_enable_o, 0);
      check("rst_acount", cif.ctrl_acount_o, 0);
      check("rst_wcount", cif.ctrl_wcount_o, 0);
      check("rst_ascan", cif.act_id_scan_o, 8'hFF);
      check("rst_wscan", cif.weight_id_scan_o, 8'hFF);
      check("rst_awren", cif.act_id_wren_o, 0);
      check("rst_wwren", cif.weight_id_wren_o, 0);
      check("rst_wdata", cif.w_data_o, 0);
      check("rst_adata", cif.a_data_o, 0);
      check("rst_wtx", cif.weight_mcn_tag_target_x_o, 8'hFF);
      check("rst_wty", cif.weight_mcn_tag_target_y_o, 8'hFF);
      check("rst_atx", cif.act_mcn_tag_target_x_o, 8'hFF);
      check("rst_aty", cif.act_mcn_tag_target_y_o, 8'hFF);
      check("rst_start", cif.start_compute_o, 0);
   endtask

   // flag_mode 0: flag held high all run; 1: pulses before/at start and at S+1+f_extra
   task automatic run(input logic [15:0] base, input int w, input int a, input int flag_mode,
                      input int f_extra, input int restart_at, input int rst_at);
      int kind[$];
      logic [15:0] saddr[$];
      logic [15:0] ad;
      int nslots, S, F, D, s, j;
      logic [7:0] wd, e_wtx, e_wty, e_atx, e_aty;
      bit e_awren, e_wwren, e_start, e_rd;
      ad = base;
      for (int i = 0; i < P; i++) kind.push_back(K_AID);
      kind.push_back(K_AWR);
      for (int i = 0; i < P; i++) kind.push_back(K_WID);
      kind.push_back(K_WWR);
      for (int r = 0; r < w; r++) begin
         kind.push_back(K_WTY); kind.push_back(K_WTX);
         for (int c = 0; c < w; c++) kind.push_back(K_WD);
      end
      for (int r = 0; r < a; r++) begin
         kind.push_back(K_ATY); kind.push_back(K_ATX);
         for (int c = 0; c < a; c++) kind.push_back(K_AD);
      end
      kind.push_back(K_NONE);
      kind.push_back(K_ST);
      foreach (kind[i]) begin
         saddr.push_back(ad);
         if (is_read(kind[i])) ad = ad + 16'd1;
      end
      nslots = kind.size();
      S = nslots + 2;
      F = S + 1 + f_extra;
      D = (flag_mode == 0) ? S + 2 : F + 1;

      @(negedge clk);
      cif.cfg_base_addr_i = base;
      cif.cfg_acount_i = 8'(a);
      cif.cfg_wcount_i = 8'(w);
      cif.cfg_start_i = 1'b1;
      cif.flag_done_i = (flag_mode == 0);
      m_acnt = 8'(a);
      m_wcnt = 8'(w);

      for (int o = 1; o <= D + 1; o++) begin
         @(negedge clk);
         if (o == rst_at + 1) begin
            check_reset_state();
            rst = 1'b0;
            cif.cfg_start_i = 1'b0;
            cif.flag_done_i = 1'b0;
            model_reset();
            return;
         end
         s = o - 3;
         e_awren = 0; e_wwren = 0; e_start = 0;
         e_wtx = 8'hFF; e_wty = 8'hFF; e_atx = 8'hFF; e_aty = 8'hFF;
         if (s >= 0 && s < nslots) begin
            wd = word_of(saddr[s]);
            case (kind[s])
               K_AID: m_ascan = wd;
               K_WID: m_wscan = wd;
               K_AWR: e_awren = 1;
               K_WWR: e_wwren = 1;
               K_WTY: m_wty = wd;
               K_WTX: m_wtx = wd;
               K_ATY: m_aty = wd;
               K_ATX: m_atx = wd;
               K_WD: begin m_wdata = wd; e_wtx = m_wtx; e_wty = m_wty; end
               K_AD: begin m_adata = wd; e_atx = m_atx; e_aty = m_aty; end
               K_ST: e_start = 1;
               default: ;
            endcase
         end
         j = o - 1;
         e_rd = (j < nslots) ? is_read(kind[j]) : 1'b0;

         check("busy", cif.busy_o, (o < D));
         check("done", cif.done_o, (o == D));
         check("enable", cif.cluster_enable_o, (o <= D));
         check("cfg_err", cif.cfg_err_o, 0);
         check("rd_en", cif.mem_rd_en_o, e_rd);
         if (e_rd) check("rd_addr", cif.mem_rd_addr_o, saddr[j]);
         check("acount", cif.ctrl_acount_o, m_acnt);
         check("wcount", cif.ctrl_wcount_o, m_wcnt);
         check("ascan", cif.act_id_scan_o, m_ascan);
         check("wscan", cif.weight_id_scan_o, m_wscan);
         check("awren", cif.act_id_wren_o, e_awren);
         check("wwren", cif.weight_id_wren_o, e_wwren);
         check("wdata", cif.w_data_o, m_wdata);
         check("adata", cif.a_data_o, m_adata);
         check("wtag_x", cif.weight_mcn_tag_target_x_o, e_wtx);
         check("wtag_y", cif.weight_mcn_tag_target_y_o, e_wty);
         check("atag_x", cif.act_mcn_tag_target_x_o, e_atx);
         check("atag_y", cif.act_mcn_tag_target_y_o, e_aty);
         check("start_compute", cif.start_compute_o, e_start);

         cif.cfg_start_i = (o == restart_at);
         if (o == restart_at) begin
            cif.cfg_base_addr_i = ~base;
            cif.cfg_wcount_i = 8'd0;
         end
         if (flag_mode != 0) cif.flag_done_i = (o == S - 2) || (o == S) || (o == F);
         if (o == rst_at) rst = 1'b1;
      end
      cif.flag_done_i = 1'b0;
   endtask

   task automatic cfg_err_test(input int w, input int a);
      @(negedge clk);
      cif.cfg_base_addr_i = 16'h0055;
      cif.cfg_acount_i = 8'(a);
      cif.cfg_wcount_i = 8'(w);
      cif.cfg_start_i = 1'b1;
      @(negedge clk);
      cif.cfg_start_i = 1'b0;
      check("err_pulse", cif.cfg_err_o, 1);
      check("err_rd_en", cif.mem_rd_en_o, 0);
      check("err_busy", cif.busy_o, 0);
      check("err_enable", cif.cluster_enable_o, 0);
      check("err_wcount", cif.ctrl_wcount_o, m_wcnt);
      @(negedge clk);
      check("err_clear", cif.cfg_err_o, 0);
      check("err_rd_en2", cif.mem_rd_en_o, 0);
      check("err_busy2", cif.busy_o, 0);
   endtask

   initial begin
      int w, a;
      n_tests = 0;
      n_fail = 0;
      salt = 8'h00;
      rst = 1'b1;
      cif.cfg_start_i = 1'b0;
      cif.cfg_base_addr_i = '0;
      cif.cfg_acount_i = '0;
      cif.cfg_wcount_i = '0;
      cif.flag_done_i = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_state();
      rst = 1'b0;

      run(16'h0000, 3, 6, 0, 0, -1, -1);   // stale flag held high
      run(16'h0000, 3, 6, 1, 10, 50, -1);  // flag pulse at k+110, ignored restart at k+50
      cfg_err_test(0, 5);
      cfg_err_test(3, 2);
      run(16'h0000, 3, 6, 0, 0, -1, 60);   // reset during act load
      run(16'h0100, 3, 6, 1, 3, -1, -1);

      for (int i = 0; i < 8; i++) begin
         w = $urandom_range(1, 4);
         a = $urandom_range(w, 6);
         salt = 8'($urandom);
         run(16'($urandom), w, a, $urandom_range(0, 1), $urandom_range(0, 6),
             ($urandom_range(0, 1) == 1) ? $urandom_range(2, 20) : -1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
